msg_beat_assembler: RTL and testbench

Downstream consumer of the simulation message-sink beat stream. It accepts 32-bit beats with a `last` marker and parses the leading header beat (method id, word count). It collects the payload words into a flat buffer and presents one complete message per handshake to the request-dispatch logic. Malformed messages are dropped and counted instead of being delivered.

---
 rtl/msg_beat_assembler_pkg.sv | 18 +
 rtl/msg_beat_assembler_if.sv | 26 ++
 rtl/msg_beat_assembler.sv | 129 ++++++++++++
 tb/tb_msg_beat_assembler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_beat_assembler_pkg.sv
// Shared types and header field positions for the message beat assembler.
package msg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DRAIN   = 2'd2,
    DELIVER = 2'd3
  } state_e;

  localparam int HDR_ID_MSB  = 31;
  localparam int HDR_ID_LSB  = 16;
  localparam int HDR_LEN_MSB = 15;
  localparam int HDR_LEN_LSB = 0;

  localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/msg_beat_assembler_if.sv
// Beat-in / message-out bundle between the beat source, the assembler and the dispatcher.
interface msg_beat_assembler_if #(
  parameter int width     = 32,
  parameter int MAX_WORDS = 4
);
  logic                       EN_beat;
  logic                       RDY_beat;
  logic [width-1:0]           beat;
  logic                       last;
  logic                       EN_msg;
  logic                       RDY_msg;
  logic [15:0]                msg_id;
  logic [15:0]                msg_words;
  logic [MAX_WORDS*width-1:0] msg_data;
  logic [7:0]                 err_count;

  modport slave (
    input  EN_beat, beat, last, RDY_msg,
    output RDY_beat, EN_msg, msg_id, msg_words, msg_data, err_count
  );

  modport master (
    output EN_beat, beat, last, RDY_msg,
    input  RDY_beat, EN_msg, msg_id, msg_words, msg_data, err_count
  );
endinterface

// File: rtl/msg_beat_assembler.sv
// Collects header + payload beats into one flat message; malformed messages are
// dropped and counted in a saturating error counter.
module msg_beat_assembler
  import msg_pkg::*;
#(
  parameter int width     = 32,
  parameter int MAX_WORDS = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  msg_beat_assembler_if.slave  bus
);

  localparam int          IDX_W   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      id_q, id_d;
  logic [15:0]      words_q, words_d;
  logic [width-1:0] data_q [MAX_WORDS];
  logic [width-1:0] data_d [MAX_WORDS];
  logic [7:0]       err_q, err_d;

  logic [15:0] hdr_len;
  logic [15:0] hdr_id;
  logic        final_word;
  logic        drop;

  assign hdr_len    = bus.beat[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_id     = bus.beat[HDR_ID_MSB:HDR_ID_LSB];
  assign final_word = (16'(idx_q) == (len_q - 16'd2));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    id_d    = id_q;
    words_d = words_q;
    data_d  = data_q;
    err_d   = err_q;
    drop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.EN_beat) begin
          if (hdr_len == 16'd1 && bus.last) begin
            state_d = DELIVER;
            id_d    = hdr_id;
            words_d = 16'd0;
            for (int i = 0; i < MAX_WORDS; i++) data_d[i] = '0;
          end else if (hdr_len >= 16'd2 && hdr_len <= MAX_LEN) begin
            if (bus.last) begin
              drop = 1'b1;
            end else begin
              state_d = PAYLOAD;
              id_d    = hdr_id;
              words_d = hdr_len - 16'd1;
              len_d   = hdr_len;
              idx_d   = '0;
              for (int i = 0; i < MAX_WORDS; i++) data_d[i] = '0;
            end
          end else if (bus.last) begin
            drop = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      PAYLOAD: begin
        if (bus.EN_beat) begin
          data_d[idx_q] = bus.beat;
          idx_d         = idx_q + 1'b1;
          if (final_word) begin
            state_d = bus.last ? DELIVER : DRAIN;
          end else if (bus.last) begin
            state_d = IDLE;
            drop    = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.EN_beat && bus.last) begin
          state_d = IDLE;
          drop    = 1'b1;
        end
      end
      DELIVER: begin
        if (bus.RDY_msg) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (drop && err_q != ERR_MAX) err_d = err_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
      words_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < MAX_WORDS; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      id_q    <= id_d;
      words_q <= words_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Ready drops with reset so no beat can be taken while state is being cleared.
  assign bus.RDY_beat  = (state_q != DELIVER) && RST_N;
  assign bus.EN_msg    = (state_q == DELIVER) && bus.RDY_msg;
  assign bus.msg_id    = id_q;
  assign bus.msg_words = words_q;
  assign bus.err_count = err_q;

  for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_flat
    assign bus.msg_data[gi*width +: width] = data_q[gi];
  end

endmodule

// File: tb/tb_msg_beat_assembler.sv
// Randomized self-checking bench; the model judges each message as a whole
// (delivered only when 1 <= L <= MAX_WORDS+1 and exactly L beats arrive).
module tb_msg_beat_assembler;

  localparam int W  = 32;
  localparam int MW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msg_beat_assembler_if #(.width(W), .MAX_WORDS(MW)) bus ();

  msg_beat_assembler #(.width(W), .MAX_WORDS(MW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int err_exp  = 0;
  logic [31:0] fixed_q [$];

  task automatic send_beat(input logic [31:0] d, input logic l);
    int guard = 0;
    while (bus.RDY_beat !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL beat_ready_timeout: RDY_beat=%b required 1", bus.RDY_beat);
    end
    bus.EN_beat = 1'b1;
    bus.beat    = d;
    bus.last    = l;
    @(posedge clk);
    #1;
    bus.EN_beat = 1'b0;
    bus.last    = 1'b0;
    bus.beat    = $urandom;
  endtask

  // Sends header + (n-1) payload beats; fixed_q supplies payload when non-empty.
  task automatic run_msg(input logic [15:0] id, input logic [15:0] len, input int n,
                         input string tag, output logic [MW*W-1:0] exp_data);
    logic [31:0] pay [$];
    logic [31:0] v;
    bit ok;
    ok = (len >= 16'd1) && (len <= 16'(MW + 1)) && (n == int'(len));
    send_beat({id, len}, n == 1);
    for (int k = 1; k < n; k++) begin
      if (fixed_q.size() > 0) v = fixed_q.pop_front();
      else v = $urandom;
      pay.push_back(v);
      send_beat(v, k == n - 1);
    end
    exp_data = '0;
    if (ok) begin
      for (int k = 0; k < pay.size(); k++) exp_data[k*W +: W] = pay[k];
    end else if (err_exp < 255) begin
      err_exp++;
    end
    @(negedge clk);
    n_checks++;
    if (bus.EN_msg !== (ok && bus.RDY_msg)) begin
      n_fail++;
      $display("FAIL %s_en_msg: got %b required %b", tag, bus.EN_msg, ok && bus.RDY_msg);
    end
    n_checks++;
    if (bus.err_count !== 8'(err_exp)) begin
      n_fail++;
      $display("FAIL %s_err_count: got %0d required %0d", tag, bus.err_count, err_exp);
    end
    if (ok) begin
      n_checks++;
      if (bus.msg_id !== id) begin
        n_fail++;
        $display("FAIL %s_msg_id: got %h required %h", tag, bus.msg_id, id);
      end
      n_checks++;
      if (bus.msg_words !== len - 16'd1) begin
        n_fail++;
        $display("FAIL %s_msg_words: got %0d required %0d", tag, bus.msg_words, len - 16'd1);
      end
      n_checks++;
      if (bus.msg_data !== exp_data) begin
        n_fail++;
        $display("FAIL %s_msg_data: got %h required %h", tag, bus.msg_data, exp_data);
      end
      if (bus.RDY_msg) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.RDY_beat !== 1'b0 || bus.EN_msg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: RDY_beat=%b EN_msg=%b required 0 0", bus.RDY_beat, bus.EN_msg);
    end
    n_checks++;
    if (bus.msg_id !== 16'd0 || bus.msg_words !== 16'd0 || bus.msg_data !== '0 || bus.err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: id=%h words=%h data=%h err=%h required all 0",
               bus.msg_id, bus.msg_words, bus.msg_data, bus.err_count);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.RDY_beat !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: got %b required 1", bus.RDY_beat);
    end
  endtask

  task automatic test_basic();
    logic [MW*W-1:0] d;
    fixed_q = '{32'h0000_000A, 32'h0000_000B};
    run_msg(16'h0005, 16'd3, 3, "basic", d);
    @(negedge clk);
    n_checks++;
    if (bus.EN_msg !== 1'b0 || bus.RDY_beat !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_pulse_end: EN_msg=%b RDY_beat=%b required 0 1", bus.EN_msg, bus.RDY_beat);
    end
  endtask

  task automatic test_single();
    logic [MW*W-1:0] d;
    run_msg(16'h0007, 16'd1, 1, "single", d);
  endtask

  task automatic test_backpressure();
    logic [MW*W-1:0] d;
    bus.RDY_msg = 1'b0;
    run_msg(16'h1234, 16'd4, 4, "bp", d);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.RDY_beat !== 1'b0 || bus.EN_msg !== 1'b0 || bus.msg_id !== 16'h1234 ||
          bus.msg_words !== 16'd3 || bus.msg_data !== d) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: RDY_beat=%b EN_msg=%b id=%h words=%0d data=%h required 0 0 1234 3 %h",
                 c, bus.RDY_beat, bus.EN_msg, bus.msg_id, bus.msg_words, bus.msg_data, d);
      end
      @(negedge clk);
    end
    bus.RDY_msg = 1'b1;
    #1;
    n_checks++;
    if (bus.EN_msg !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: EN_msg=%b required 1", bus.EN_msg);
    end
    @(negedge clk);
    n_checks++;
    if (bus.EN_msg !== 1'b0 || bus.RDY_beat !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_single_pulse: EN_msg=%b RDY_beat=%b required 0 1", bus.EN_msg, bus.RDY_beat);
    end
  endtask

  task automatic test_truncated();
    logic [MW*W-1:0] d;
    run_msg(16'h0003, 16'd3, 2, "trunc", d);
    run_msg(16'h0009, 16'd3, 3, "trunc_next", d);
  endtask

  task automatic test_oversize();
    logic [MW*W-1:0] d;
    run_msg(16'h000B, 16'd9, 9, "oversize", d);
  endtask

  task automatic test_back_to_back();
    logic [MW*W-1:0] d;
    run_msg(16'h0021, 16'd2, 2, "b2b_a", d);
    n_checks++;
    if (bus.RDY_beat !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b required 1", bus.RDY_beat);
    end
    run_msg(16'h0022, 16'd5, 5, "b2b_b", d);
    run_msg(16'h0023, 16'd1, 1, "b2b_c", d);
  endtask

  task automatic test_random();
    logic [MW*W-1:0] d;
    int len, n;
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0 && len >= 1) n = len;
      else n = $urandom_range(1, 7);
      run_msg(16'($urandom), 16'(len), n, "rand", d);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      send_beat({16'h0001, 16'h0000}, 1'b1);
      if (err_exp < 255) err_exp++;
    end
    @(negedge clk);
    n_checks++;
    if (bus.err_count !== 8'(err_exp)) begin
      n_fail++;
      $display("FAIL saturate: got %0d required %0d", bus.err_count, err_exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [MW*W-1:0] d;
    send_beat({16'h00AA, 16'd4}, 1'b0);
    send_beat(32'hDEAD_BEEF, 1'b0);
    rst_n = 1'b0;
    #1;
    err_exp = 0;
    n_checks++;
    if (bus.msg_id !== 16'd0 || bus.msg_words !== 16'd0 || bus.msg_data !== '0 ||
        bus.err_count !== 8'd0 || bus.RDY_beat !== 1'b0 || bus.EN_msg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: id=%h words=%h data=%h err=%h rdy=%b en=%b required all 0",
               bus.msg_id, bus.msg_words, bus.msg_data, bus.err_count, bus.RDY_beat, bus.EN_msg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.RDY_beat !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_rdy: got %b required 1", bus.RDY_beat);
    end
    run_msg(16'h0042, 16'd4, 4, "after_reset", d);
  endtask

  initial begin
    bus.EN_beat = 1'b0;
    bus.beat    = '0;
    bus.last    = 1'b0;
    bus.RDY_msg = 1'b1;
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_truncated();
    test_oversize();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
